// File: rtl/mem_resp_pkg.sv
// Shared definitions for the LC-3 memory responder: FSM state encoding,
// the memory-mapped I/O address and the wait-state counter width.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Address decoded as the switch/hex-display register when MMIO is built in
    localparam logic [15:0] MMIO_ADDR = 16'hFFFF;

    // Wait-state counter width; WAIT_STATES must fit in it (0..15)
    localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM backing the memory responder.
// Writes and reads both happen at the edge where en is high; the read
// result is held in a resettable output register until the next read.
module mem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    // Storage write; contents are deliberately left out of reset
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read data register, cleared on reset and updated only by a read access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 16'h0000;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the LC-3 MAR/MDR interface. Captures a request,
// waits WAIT_STATES cycles, commits the access and pulses R for one cycle.
// Optional feature: define MEM_RESP_MMIO_EN to decode address 16'hFFFF as
// the switch (read) / hex-display (write) register instead of memory.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic [15:0] SW,
    output logic [15:0] MDR_In,
    output logic        R,
    output logic [15:0] HEX_Out
);

    localparam int AW = $clog2(DEPTH);

    state_t              state;
    state_t              next_state;
    logic [15:0]         addr_q;
    logic [15:0]         data_q;
    logic                wr_q;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                commit;
    logic                is_io;
    logic                ram_en;
    logic                ram_we;
    logic [15:0]         ram_rdata;

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; dropping MIO_EN while busy abandons the access
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (MIO_EN) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (!MIO_EN) begin
                    next_state = IDLE;
                end else if (wait_cnt == '0) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: ready pulse and the single commit strobe for the access
    always_comb begin
        R      = 1'b0;
        commit = 1'b0;
        if (state == DONE) begin
            R = 1'b1;
        end
        if (state == BUSY && MIO_EN && wait_cnt == '0) begin
            commit = 1'b1;
        end
    end

    // Request capture and wait-state countdown; inputs are ignored after capture
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            addr_q   <= 16'h0000;
            data_q   <= 16'h0000;
            wr_q     <= 1'b0;
            wait_cnt <= '0;
        end else if (state == IDLE && MIO_EN) begin
            addr_q   <= MAR;
            data_q   <= MDR;
            wr_q     <= R_W;
            wait_cnt <= WAIT_W'(WAIT_STATES);
        end else if (state == BUSY && MIO_EN && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

`ifdef MEM_RESP_MMIO_EN
    logic        io_sel_q;
    logic [15:0] io_rdata_q;

    assign is_io = (addr_q == MMIO_ADDR);

    // I/O register access; io_sel_q remembers whether the last read was I/O
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            io_sel_q   <= 1'b0;
            io_rdata_q <= 16'h0000;
            HEX_Out    <= 16'h0000;
        end else if (commit) begin
            if (is_io) begin
                if (wr_q) begin
                    HEX_Out <= data_q;
                end else begin
                    io_sel_q   <= 1'b1;
                    io_rdata_q <= SW;
                end
            end else if (!wr_q) begin
                io_sel_q <= 1'b0;
            end
        end
    end

    assign MDR_In = io_sel_q ? io_rdata_q : ram_rdata;
`else
    logic unused_bits;

    assign is_io       = 1'b0;
    assign HEX_Out     = 16'h0000;
    assign MDR_In      = ram_rdata;
    assign unused_bits = &{1'b0, SW, addr_q};
`endif

    assign ram_en = commit && !is_io;
    assign ram_we = wr_q;

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (Clk),
        .rst_n (Reset),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr_q[AW-1:0]),
        .wdata (data_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: one instance with WAIT_STATES=2
// (slot 0) and one with WAIT_STATES=0 (slot 1). Read expectations are queued
// from a reference memory model when a request is driven and popped on R.
// Build with MEM_RESP_MMIO_EN defined to exercise the I/O register path.
module tb_mem_responder;

    logic        Clk;
    logic        Reset;

    logic        mio_a, rw_a, r_a;
    logic [15:0] mar_a, mdr_a, sw_a, mdr_in_a, hex_a;
    logic        mio_b, rw_b, r_b;
    logic [15:0] mar_b, mdr_b, sw_b, mdr_in_b, hex_b;

    int errors = 0;
    int checks = 0;

    logic [15:0] model_a [1024];
    logic [15:0] model_b [1024];
    logic [15:0] exp_q_a [$];
    logic [15:0] exp_q_b [$];
    logic [15:0] last_rd [2];
    logic [15:0] exp_hex;

    mem_responder #(.DEPTH(1024), .WAIT_STATES(2)) dut (
        .Clk(Clk), .Reset(Reset), .MIO_EN(mio_a), .R_W(rw_a), .MAR(mar_a),
        .MDR(mdr_a), .SW(sw_a), .MDR_In(mdr_in_a), .R(r_a), .HEX_Out(hex_a)
    );

    mem_responder #(.DEPTH(1024), .WAIT_STATES(0)) dut_fast (
        .Clk(Clk), .Reset(Reset), .MIO_EN(mio_b), .R_W(rw_b), .MAR(mar_b),
        .MDR(mdr_b), .SW(sw_b), .MDR_In(mdr_in_b), .R(r_b), .HEX_Out(hex_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic getR(input bit sel);
        return sel ? r_b : r_a;
    endfunction

    function automatic logic [15:0] getMdr(input bit sel);
        return sel ? mdr_in_b : mdr_in_a;
    endfunction

    task automatic driveReq(input bit sel, input logic wr, input logic [15:0] addr,
                            input logic [15:0] data);
        if (sel) begin
            mio_b = 1'b1; rw_b = wr; mar_b = addr; mdr_b = data;
        end else begin
            mio_a = 1'b1; rw_a = wr; mar_a = addr; mdr_a = data;
        end
    endtask

    task automatic dropReq(input bit sel);
        if (sel) mio_b = 1'b0;
        else     mio_a = 1'b0;
    endtask

    // Expected read result for an address at the moment the request is driven
    function automatic logic [15:0] modelRead(input bit sel, input logic [15:0] addr);
        logic [9:0] idx;
        idx = addr[9:0];
`ifdef MEM_RESP_MMIO_EN
        if (addr == 16'hFFFF) return sel ? sw_b : sw_a;
`endif
        return sel ? model_b[idx] : model_a[idx];
    endfunction

    task automatic modelWrite(input bit sel, input logic [15:0] addr, input logic [15:0] data);
        logic [9:0] idx;
        idx = addr[9:0];
`ifdef MEM_RESP_MMIO_EN
        if (addr == 16'hFFFF) begin
            if (!sel) exp_hex = data;
            return;
        end
`endif
        if (sel) model_b[idx] = data;
        else     model_a[idx] = data;
    endtask

    // Full request/response handshake with latency, data and pulse-width checks
    task automatic applyStimulus(input bit sel, input logic wr, input logic [15:0] addr,
                                 input logic [15:0] data, input string tag);
        int          lat;
        int          exp_lat;
        logic [15:0] exp;
        exp_lat = sel ? 2 : 4;
        if (wr) begin
            modelWrite(sel, addr, data);
        end else begin
            if (sel) exp_q_b.push_back(modelRead(sel, addr));
            else     exp_q_a.push_back(modelRead(sel, addr));
        end
        @(negedge Clk);
        driveReq(sel, wr, addr, data);
        @(negedge Clk);
        driveReq(sel, ~wr, ~addr, ~data);
        lat = 1;
        while (!getR(sel) && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, exp_lat);
        if (getR(sel)) begin
            if (!wr) begin
                exp = 16'h0000;
                if (sel && exp_q_b.size() > 0)       exp = exp_q_b.pop_front();
                else if (!sel && exp_q_a.size() > 0) exp = exp_q_a.pop_front();
                checkOutput({tag, "_rdata"}, getMdr(sel), exp);
                last_rd[sel] = exp;
            end else begin
                checkOutput({tag, "_mdr_hold"}, getMdr(sel), last_rd[sel]);
            end
        end
        dropReq(sel);
        @(negedge Clk);
        checkOutput({tag, "_r_pulse"}, getR(sel), 1'b0);
    endtask

    initial begin
        logic        seen_r;
        logic [15:0] prior_mdr;
        int          rcount;

        Reset = 1'b0;
        mio_a = 0; rw_a = 0; mar_a = 0; mdr_a = 0; sw_a = 0;
        mio_b = 0; rw_b = 0; mar_b = 0; mdr_b = 0; sw_b = 0;
        last_rd[0] = 16'h0000;
        last_rd[1] = 16'h0000;
        exp_hex    = 16'h0000;
        repeat (2) @(negedge Clk);
        checkOutput("reset_mdr_in", mdr_in_a, 16'h0000);
        checkOutput("reset_r", r_a, 1'b0);
        checkOutput("reset_hex", hex_a, 16'h0000);
        Reset = 1'b1;
        @(negedge Clk);

        $display("[TB] write then read");
        applyStimulus(0, 1'b1, 16'h0010, 16'hBEEF, "wr_beef");
        applyStimulus(0, 1'b0, 16'h0010, 16'h0000, "rd_beef");

        $display("[TB] address aliasing");
        applyStimulus(0, 1'b1, 16'h0400, 16'h1234, "wr_alias");
        applyStimulus(0, 1'b0, 16'h0000, 16'h0000, "rd_alias");

        $display("[TB] abort during busy");
        applyStimulus(0, 1'b1, 16'h0005, 16'h5555, "wr_prior");
        prior_mdr = mdr_in_a;
        @(negedge Clk);
        driveReq(0, 1'b1, 16'h0005, 16'hAAAA);
        repeat (2) @(negedge Clk);
        dropReq(0);
        seen_r = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            seen_r = seen_r | r_a;
        end
        checkOutput("abort_no_r", seen_r, 1'b0);
        checkOutput("abort_mdr_same", mdr_in_a, prior_mdr);
        applyStimulus(0, 1'b0, 16'h0005, 16'h0000, "rd_after_abort");

        $display("[TB] top address handling");
        sw_a = 16'h00C3;
`ifdef MEM_RESP_MMIO_EN
        applyStimulus(0, 1'b1, 16'h03FF, 16'h0011, "wr_3ff");
        applyStimulus(0, 1'b0, 16'hFFFF, 16'h0000, "rd_sw");
        applyStimulus(0, 1'b1, 16'hFFFF, 16'h0042, "wr_hex");
        checkOutput("hex_out", hex_a, exp_hex);
        applyStimulus(0, 1'b0, 16'h03FF, 16'h0000, "rd_3ff_kept");
`else
        applyStimulus(0, 1'b1, 16'hFFFF, 16'h7777, "wr_ffff_alias");
        checkOutput("hex_tied_zero", hex_a, 16'h0000);
        applyStimulus(0, 1'b0, 16'h03FF, 16'h0000, "rd_3ff_alias");
`endif

        $display("[TB] zero wait states back-to-back");
        applyStimulus(1, 1'b1, 16'h0020, 16'h1111, "fast_wr0");
        applyStimulus(1, 1'b1, 16'h0021, 16'h2222, "fast_wr1");
        exp_q_b.push_back(modelRead(1, 16'h0020));
        exp_q_b.push_back(modelRead(1, 16'h0021));
        @(negedge Clk);
        driveReq(1, 1'b0, 16'h0020, 16'h0000);
        rcount = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge Clk);
            if (r_b) begin
                rcount++;
                if (rcount == 1) begin
                    checkOutput("b2b_first_cycle", cyc, 2);
                    checkOutput("b2b_first_data", mdr_in_b, exp_q_b.pop_front());
                    mar_b = 16'h0021;
                end else begin
                    checkOutput("b2b_second_cycle", cyc, 5);
                    checkOutput("b2b_second_data", mdr_in_b, exp_q_b.pop_front());
                    dropReq(1);
                    break;
                end
            end
        end
        dropReq(1);
        checkOutput("b2b_count", rcount, 2);
        @(negedge Clk);

        $display("[TB] reset during busy read");
        applyStimulus(0, 1'b0, 16'h0010, 16'h0000, "rd_before_reset");
        @(negedge Clk);
        driveReq(0, 1'b0, 16'h0010, 16'h0000);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        checkOutput("rst_mid_mdr_in", mdr_in_a, 16'h0000);
        checkOutput("rst_mid_r", r_a, 1'b0);
        checkOutput("rst_mid_hex", hex_a, 16'h0000);
        last_rd[0] = 16'h0000;
        last_rd[1] = 16'h0000;
        exp_hex    = 16'h0000;
        @(negedge Clk);
        dropReq(0);
        Reset = 1'b1;
        seen_r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            seen_r = seen_r | r_a;
        end
        checkOutput("rst_mid_no_r", seen_r, 1'b0);
        applyStimulus(0, 1'b0, 16'h0010, 16'h0000, "rd_after_reset");

        repeat (2) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the LC-3 datapath's MAR/MDR memory interface. It samples an access request (address from MAR, write data from MDR, direction, MIO_EN), runs a configurable wait-state counter, then either commits a write or returns read data on MDR_In with a one-cycle ready pulse. It sits between the datapath and on-chip word memory, and can optionally decode a memory-mapped switch/hex-display register.

## Interface
- DEPTH, 1024: words of backing memory; power of two, 2 to 65536.
- WAIT_STATES, 2: extra cycles between request capture and completion; 0 to 15.
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- MIO_EN  in  1  access request; held high by the datapath FSM until R is seen.
- R_W  in  1  direction; 1 = write, 0 = read; sampled with MIO_EN.
- MAR  in  16  word address.
- MDR  in  16  write data.
- SW  in  16  switch inputs (MMIO read source).
- MDR_In  out  16  read data back to the datapath MDR mux.
- R  out  1  ready; one-cycle pulse marking completion.
- HEX_Out  out  16  hex-display register (MMIO write target).

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: on MIO_EN=1, capture MAR, MDR and R_W into internal registers, load the wait counter with WAIT_STATES, and go to BUSY.
- BUSY: if MIO_EN=0, abort to IDLE with no write, no R and MDR_In unchanged. If the counter is 0, perform the access and go to DONE. Otherwise decrement the counter.
- Access: memory index is captured address mod DEPTH, so high bits alias.
  - Read: MDR_In <= memory word, or the MMIO source.
  - Write: the memory word, or HEX_Out, <= captured data; MDR_In is unchanged.
- DONE: R=1 for exactly this cycle, then return to IDLE unconditionally.
- Back-to-back requests: if MIO_EN is still high in IDLE the cycle after DONE, it is a new request.
- Captured address, data and direction are used throughout. MAR, MDR and R_W changes after capture are ignored.
- MDR_In holds the last completed read value until the next read completes.
- Reset values: state IDLE, MDR_In=16'h0000, R=0, HEX_Out=16'h0000, wait counter 0. Memory contents are not reset.
- Reset asserted mid-access (IDLE or BUSY) aborts it: no write is committed and R is not pulsed.

## Timing
- Request sampled at edge T0, where MIO_EN=1 in IDLE.
- Access commits at edge T0+WAIT_STATES+1.
- R is high during the cycle after that edge.
- MDR_In is valid in the same cycle as R and stays stable afterward.
- Total request-to-R latency is WAIT_STATES+2 edges; with WAIT_STATES=0, R is high two cycles after the request.
- No combinational path from any input to MDR_In or R.
- Minimum request spacing is WAIT_STATES+3 cycles.

## Configuration
- MEM_RESP_MMIO_EN defined: captured address 16'hFFFF is decoded as I/O.
  - Read returns SW.
  - Write loads HEX_Out.
  - Backing memory is not touched.
- Not defined: 16'hFFFF is an ordinary (aliased) memory address, HEX_Out is tied to 16'h0000, and SW is unused.

## Structure
- Shared package mem_resp_pkg:
  - enum type for the IDLE/BUSY/DONE states.
  - constant MMIO_ADDR = 16'hFFFF.
  - width of the wait counter (4 bits).
- One sub-module, mem_array:
  - single-port synchronous word RAM with DEPTH words and $clog2(DEPTH) address bits.
  - write-enable and read performed at the commit edge.
- FSM, capture registers, counter and MMIO decode live in mem_responder.

## Test plan
- Write then read: WAIT_STATES=2; write 16'hBEEF to 16'h0010, then read 16'h0010 -> R pulses 4 cycles after each request; MDR_In=16'hBEEF with R.
- Aliasing: DEPTH=1024; write 16'h1234 to 16'h0400, read 16'h0000 -> 16'h1234.
- Abort: drop MIO_EN during BUSY of a write of 16'hAAAA to 16'h0005 -> no R; a later read of 16'h0005 returns the prior contents; MDR_In unchanged.
- Reset mid-read: assert Reset during BUSY -> MDR_In=0, R=0, state IDLE immediately; the next read completes normally.
- MMIO with MEM_RESP_MMIO_EN:
  - SW=16'h00C3, read 16'hFFFF -> MDR_In=16'h00C3.
  - Write 16'h0042 to 16'hFFFF -> HEX_Out=16'h0042 and memory word 16'h3FF unchanged.
- WAIT_STATES=0 back-to-back: hold MIO_EN for two reads -> R pulses at cycles 2 and 5 after the first request.
